// File: rtl/matrix_loader_pkg.sv
// matrix_loader_pkg: shared types and constants for the matrix loader slice.
//   state_t : loader FSM states
//   NN/IDX_W: element count and index width for the default 3x3 build;
//             modules re-derive these from their own N via idx_bits()
//   CYC_W   : compute-window cycle counter width
package matrix_loader_pkg;

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int N_DEF = 3;
   localparam int NN    = N_DEF * N_DEF;
   localparam int IDX_W = $clog2(NN);
   localparam int CYC_W = 8;

   // Index width for an n x n operand; a 1x1 operand still needs one bit.
   function automatic int idx_bits(input int n);
      return (n * n > 1) ? $clog2(n * n) : 1;
   endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// matrix_loader_if: element stream into the loader.
//   valid : upstream element valid
//   ready : loader can accept an element this cycle
//   data  : element value (W bits)
//   mode  : operation mode, meaningful on the final B element
// Modports: master (upstream producer), slave (loader).
interface matrix_loader_if #(parameter int W = 32);
   logic         valid;
   logic         ready;
   logic [W-1:0] data;
   logic         mode;

   modport master (output valid, output data, output mode, input ready);
   modport slave  (input valid, input data, input mode, output ready);
endinterface

// File: rtl/matrix_loader_slot_dec.sv
// loader_slot_dec: maps the running element index to the packed-bus slot
// the element is written to.
//   idx  : element index within the current operand (0..N*N-1)
//   is_b : 1 while loading operand B
//   slot : destination slot
// Build macro LOADER_BTRANS_EN: when defined, B arrives row-major and is
// stored column-major (idx r*N+c -> slot c*N+r). A is never remapped.
module loader_slot_dec
   import matrix_loader_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [idx_bits(N)-1:0] idx,
   input  logic                   is_b,
   output logic [idx_bits(N)-1:0] slot
);

   localparam int IW = idx_bits(N);

`ifdef LOADER_BTRANS_EN
   always_comb begin
      slot = idx;
      if (is_b) slot = IW'((int'(idx) % N) * N + int'(idx) / N);
   end
`else
   logic unused_is_b;
   assign unused_is_b = is_b;
   assign slot        = idx;
`endif

endmodule

// File: rtl/matrix_loader.sv
// matrix_loader: collects N*N elements of A then N*N elements of B from a
// valid/ready stream into flat packed buses, then holds o_en high for
// COMPUTE_CYCLES cycles with the buses frozen, pulses o_done and reloads.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   s            : element stream (matrix_loader_if.slave)
//   o_A, o_B     : packed operands, element k at [(k+1)*W-1 : k*W]
//   o_en         : high during the compute window
//   o_mode       : mode captured on the final B element
//   o_done       : one-cycle pulse after the window
//   o_busy       : high during the window and the done cycle
// Build macro LOADER_BTRANS_EN: column-major packing of B (see loader_slot_dec).
module matrix_loader
   import matrix_loader_pkg::*;
#(
   parameter int W              = 32,
   parameter int N              = 3,
   parameter int COMPUTE_CYCLES = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   matrix_loader_if.slave     s,
   output logic [W*N*N-1:0]   o_A,
   output logic [W*N*N-1:0]   o_B,
   output logic               o_en,
   output logic               o_mode,
   output logic               o_done,
   output logic               o_busy
);

   localparam int NE = N * N;
   localparam int IW = idx_bits(N);

   state_t          state, state_nx;
   logic [IW-1:0]   idx;
   logic [IW-1:0]   slot;
   logic [CYC_W-1:0] cyc;
   logic            xfer;
   logic            last;
   logic            win_end;

   // ready depends on state only, so the handshake never loops through comb logic
   assign s.ready = (state == LOAD_A) || (state == LOAD_B);
   assign xfer    = s.valid && s.ready;
   assign last    = (idx == IW'(NE - 1));
   assign win_end = (cyc == CYC_W'(COMPUTE_CYCLES - 1));

   loader_slot_dec #(.N(N)) u_dec (
      .idx  (idx),
      .is_b (state == LOAD_B),
      .slot (slot)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= LOAD_A;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      o_en     = 1'b0;
      o_done   = 1'b0;
      o_busy   = 1'b0;
      case (state)
         LOAD_A: if (xfer && last) state_nx = LOAD_B;
         LOAD_B: if (xfer && last) state_nx = RUN;
         RUN: begin
            o_en   = 1'b1;
            o_busy = 1'b1;
            if (win_end) state_nx = DONE;
         end
         DONE: begin
            o_done   = 1'b1;
            o_busy   = 1'b1;
            state_nx = LOAD_A;
         end
         default: state_nx = LOAD_A;
      endcase
   end

   // Index, window counter and operand storage. Slots are written only on
   // their own transfer, so unwritten slots keep the previous pair's data.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         idx    <= '0;
         cyc    <= '0;
         o_A    <= '0;
         o_B    <= '0;
         o_mode <= 1'b0;
      end else begin
         if (xfer) idx <= last ? '0 : idx + 1'b1;

         if (state == RUN)                          cyc <= cyc + 1'b1;
         else if (xfer && last && state == LOAD_B)  cyc <= '0;

         if (xfer && state == LOAD_A) o_A[int'(slot)*W +: W] <= s.data;
         if (xfer && state == LOAD_B) begin
            o_B[int'(slot)*W +: W] <= s.data;
            if (last) o_mode <= s.mode;
         end
      end
   end

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: scoreboard bench for matrix_loader (W=32, N=3,
// COMPUTE_CYCLES=8). Expected buses are queued when a pair is streamed and
// compared when the compute window opens; a negedge monitor also checks the
// window length, done pulse and bus stability.
module tb_matrix_loader;

   localparam int W  = 32;
   localparam int N  = 3;
   localparam int NE = N * N;
   localparam int CC = 8;
   localparam int BW = W * NE;

   typedef struct {
      logic [BW-1:0] a;
      logic [BW-1:0] b;
      logic          m;
   } exp_t;

   logic          clk, rst;
   logic [BW-1:0] o_A, o_B;
   logic          o_en, o_mode, o_done, o_busy;

   matrix_loader_if #(.W(W)) sif ();

   matrix_loader #(.W(W), .N(N), .COMPUTE_CYCLES(CC)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .s      (sif),
      .o_A    (o_A),
      .o_B    (o_B),
      .o_en   (o_en),
      .o_mode (o_mode),
      .o_done (o_done),
      .o_busy (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_chk = 0;
   int   n_err = 0;
   exp_t sb[$];

   task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int bslot(input int k);
`ifdef LOADER_BTRANS_EN
      return (k % N) * N + k / N;
`else
      return k;
`endif
   endfunction

   // ---------------- monitor ----------------
   logic          prev_en, prev_done;
   int            en_cnt;
   logic [BW-1:0] hold_a, hold_b;

   always @(negedge clk) begin
      if (rst) begin
         prev_en   = 1'b0;
         prev_done = 1'b0;
         en_cnt    = 0;
      end else begin
         if (o_en && !prev_en) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_A", o_A, e.a);
               chk("sb_B", o_B, e.b);
               chk("sb_mode", o_mode, e.m);
            end
            hold_a = o_A;
            hold_b = o_B;
            en_cnt = 0;
         end
         if (o_en) begin
            en_cnt++;
            chk("busy_run", o_busy, 1);
            chk("ready_run", sif.ready, 0);
            chk("A_stable_run", o_A, hold_a);
            chk("B_stable_run", o_B, hold_b);
         end
         if (o_done) begin
            chk("en_window", en_cnt, CC);
            chk("en_off_done", o_en, 0);
            chk("busy_done", o_busy, 1);
            chk("ready_done", sif.ready, 0);
            chk("A_stable_done", o_A, hold_a);
            chk("B_stable_done", o_B, hold_b);
         end
         if (prev_done) begin
            chk("done_one_cycle", o_done, 0);
            chk("ready_after_done", sif.ready, 1);
            chk("busy_after_done", o_busy, 0);
         end
         prev_en   = o_en;
         prev_done = o_done;
      end
   end

   // ---------------- stimulus ----------------
   // Called at posedge+1; returns at posedge+1 of the cycle after the transfer.
   task automatic send(input logic [W-1:0] d, input logic m);
      int t = 0;
      sif.valid = 1'b1;
      sif.data  = d;
      sif.mode  = m;
      while (!sif.ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!sif.ready) chk("ready_timeout", 0, 1);
      @(posedge clk); #1;
      sif.valid = 1'b0;
   endtask

   task automatic load_pair(input int base_a, input int base_b, input logic m,
                            input bit gap, input bit probe, input int old_a1);
      exp_t e;
      e.a = '0;
      e.b = '0;
      for (int k = 0; k < NE; k++) begin
         e.a[k*W +: W]        = W'(base_a + k);
         e.b[bslot(k)*W +: W] = W'(base_b + k);
      end
      e.m = m;
      sb.push_back(e);
      for (int k = 0; k < 2*NE; k++) begin
         // mode is driven inverted on every beat except the last B one
         send(W'((k < NE) ? base_a + k : base_b + k - NE),
              (k == 2*NE-1) ? m : ~m);
         if (probe && k == 0) begin
            chk("probe_A0_new", o_A[W-1:0], W'(base_a));
            chk("probe_A1_old", o_A[2*W-1:W], W'(old_a1));
         end
         if (gap && k != 2*NE-1) begin
            @(posedge clk); #1;
            chk("ready_in_gap", sif.ready, 1);
            chk("en_low_load", o_en, 0);
         end
      end
   endtask

   task automatic wait_done();
      int t = 0;
      while (!o_done && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!o_done) chk("done_timeout", 0, 1);
   endtask

   initial begin
      sif.valid = 1'b0;
      sif.data  = '0;
      sif.mode  = 1'b0;
      rst       = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_A", o_A, 0);
      chk("rst_B", o_B, 0);
      chk("rst_en", o_en, 0);
      chk("rst_done", o_done, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_mode", o_mode, 0);
      chk("rst_ready", sif.ready, 1);
      @(posedge clk); #1;

      // pair 1: back-to-back, mode 1
      load_pair(1, 10, 1'b1, 1'b0, 1'b0, 0);
      @(negedge clk);
      chk("p1_en_start", o_en, 1);
      chk("p1_A0", o_A[31:0], 1);
      chk("p1_A8", o_A[287:256], 9);
      chk("p1_B0", o_B[31:0], 10);
      chk("p1_B8", o_B[287:256], 18);
      chk("p1_mode", o_mode, 1);
`ifdef LOADER_BTRANS_EN
      chk("p1_B1", o_B[63:32], 13);
      chk("p1_B3", o_B[127:96], 11);
`else
      chk("p1_B1", o_B[63:32], 11);
      chk("p1_B3", o_B[127:96], 13);
`endif
      wait_done();
      @(posedge clk); #1;

      // pair 2: valid low every other cycle, mode 0
      load_pair(1, 10, 1'b0, 1'b1, 1'b0, 0);
      @(negedge clk);
      chk("p2_en_start", o_en, 1);
      wait_done();
      @(posedge clk); #1;

      // pair 3: new data; slot 1 of A still holds 2 after the first beat
      load_pair(101, 111, 1'b1, 1'b0, 1'b1, 2);
      sif.valid = 1'b1;     // held through RUN and DONE, must not be consumed
      sif.data  = 32'hDEAD;
      @(negedge clk);
      chk("p3_en_start", o_en, 1);
      wait_done();
      @(posedge clk); #1;   // now in LOAD_A with valid still high
      chk("dead_not_taken", o_A[31:0], 101);
      @(posedge clk); #1;
      sif.valid = 1'b0;
      chk("dead_A0", o_A[31:0], 32'hDEAD);
      chk("dead_A1_old", o_A[63:32], 102);

      // reset in the middle of a load
      for (int k = 0; k < 5; k++) send(W'(200 + k), 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_A", o_A, 0);
      chk("mid_rst_B", o_B, 0);
      chk("mid_rst_mode", o_mode, 0);
      chk("mid_rst_busy", o_busy, 0);
      #2 rst = 1'b0;
      #1;
      chk("post_rst_ready", sif.ready, 1);
      @(posedge clk); #1;
      load_pair(1, 10, 1'b1, 1'b0, 1'b0, 0);
      @(negedge clk);
      chk("p4_en_start", o_en, 1);
      wait_done();
      @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
